// File: rtl/vtage_vt_write_scheduler.sv
// rtl/vtage_vt_write_scheduler.sv - value-table write scheduler: table clear sequencer plus update queue drained over two write ports
module vtage_vt_write_scheduler #(
    parameter int P_STORAGE_SIZE = 2048,
    parameter int P_DATA_WIDTH   = 32,
    parameter int P_QUEUE_DEPTH  = 4,
    localparam int LP_ADDRESS_WIDTH = $clog2(P_STORAGE_SIZE),
    localparam int LP_COUNT_WIDTH   = $clog2(P_QUEUE_DEPTH + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        upd0_valid_i,
    input  logic [LP_ADDRESS_WIDTH-1:0] upd0_addr_i,
    input  logic [P_DATA_WIDTH-1:0]     upd0_data_i,
    input  logic                        upd1_valid_i,
    input  logic [LP_ADDRESS_WIDTH-1:0] upd1_addr_i,
    input  logic [P_DATA_WIDTH-1:0]     upd1_data_i,
    output logic                        upd_ready_o,
    input  logic                        clear_req_i,
    output logic [LP_ADDRESS_WIDTH-1:0] wra_addr_o,
    output logic [P_DATA_WIDTH-1:0]     wra_data_o,
    output logic                        wra_valid_o,
    output logic [LP_ADDRESS_WIDTH-1:0] wrb_addr_o,
    output logic [P_DATA_WIDTH-1:0]     wrb_data_o,
    output logic                        wrb_valid_o,
    output logic                        busy_o,
    output logic [LP_COUNT_WIDTH-1:0]   count_o
);

    localparam int LP_PTR_WIDTH = $clog2(P_QUEUE_DEPTH);
    localparam int LP_K_WIDTH   = LP_ADDRESS_WIDTH - 1;
    localparam logic [LP_K_WIDTH-1:0] LP_K_LAST = LP_K_WIDTH'(P_STORAGE_SIZE / 2 - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                    state;
    logic [LP_K_WIDTH-1:0]     k;
    logic [LP_PTR_WIDTH-1:0]   rd_ptr;
    logic [LP_PTR_WIDTH-1:0]   wr_ptr;
    logic [LP_COUNT_WIDTH-1:0] count;

    logic [LP_ADDRESS_WIDTH-1:0] q_addr [P_QUEUE_DEPTH];
    logic [P_DATA_WIDTH-1:0]     q_data [P_QUEUE_DEPTH];

    logic [LP_PTR_WIDTH-1:0] rd_ptr_next;
    logic [LP_PTR_WIDTH-1:0] wr_slot1;
    logic                    push0;
    logic                    push1;
    logic [1:0]              push_cnt;
    logic [1:0]              pop_cnt;

    assign busy_o      = (state == CLEAR);
    assign count_o     = count;
    assign upd_ready_o = (state == RUN) &&
                         ((LP_COUNT_WIDTH'(P_QUEUE_DEPTH) - count) >= LP_COUNT_WIDTH'(2));

    assign push0       = upd_ready_o && upd0_valid_i;
    assign push1       = upd_ready_o && upd1_valid_i;
    assign push_cnt    = {1'b0, push0} + {1'b0, push1};
    assign wr_slot1    = wr_ptr + LP_PTR_WIDTH'(push0);
    assign rd_ptr_next = rd_ptr + LP_PTR_WIDTH'(1);

    // Drain decision; a pending clear suppresses writes so discarded updates never reach the table.
    always_comb begin
        wra_addr_o  = {k, 1'b0};
        wrb_addr_o  = {k, 1'b1};
        wra_data_o  = '0;
        wrb_data_o  = '0;
        wra_valid_o = (state == CLEAR);
        wrb_valid_o = (state == CLEAR);
        pop_cnt     = 2'd0;
        if (state == RUN) begin
            wra_addr_o  = q_addr[rd_ptr];
            wra_data_o  = q_data[rd_ptr];
            wrb_addr_o  = q_addr[rd_ptr_next];
            wrb_data_o  = q_data[rd_ptr_next];
            wra_valid_o = 1'b0;
            wrb_valid_o = 1'b0;
            if (!clear_req_i) begin
                if (count >= LP_COUNT_WIDTH'(2)) begin
                    pop_cnt     = 2'd2;
                    wrb_valid_o = 1'b1;
                    wra_valid_o = (q_addr[rd_ptr] != q_addr[rd_ptr_next]);
                end else if (count == LP_COUNT_WIDTH'(1)) begin
                    pop_cnt     = 2'd1;
                    wra_valid_o = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push0) begin
            q_addr[wr_ptr] <= upd0_addr_i;
            q_data[wr_ptr] <= upd0_data_i;
        end
        if (push1) begin
            q_addr[wr_slot1] <= upd1_addr_i;
            q_data[wr_slot1] <= upd1_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state  <= CLEAR;
            k      <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clear_req_i) begin
                        k <= '0;
                    end else if (k == LP_K_LAST) begin
                        state <= RUN;
                        k     <= '0;
                    end else begin
                        k <= k + LP_K_WIDTH'(1);
                    end
                end
                RUN: begin
                    if (clear_req_i) begin
                        state  <= CLEAR;
                        k      <= '0;
                        rd_ptr <= '0;
                        wr_ptr <= '0;
                        count  <= '0;
                    end else begin
                        rd_ptr <= rd_ptr + LP_PTR_WIDTH'(pop_cnt);
                        wr_ptr <= wr_ptr + LP_PTR_WIDTH'(push_cnt);
                        count  <= count + LP_COUNT_WIDTH'(push_cnt) - LP_COUNT_WIDTH'(pop_cnt);
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_vtage_vt_write_scheduler.sv
// tb/tb_vtage_vt_write_scheduler.sv - directed and randomized model-checked bench for vtage_vt_write_scheduler
module tb_vtage_vt_write_scheduler;

    localparam int SS = 8;
    localparam int QD = 4;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          upd0_valid = 1'b0, upd1_valid = 1'b0;
    logic [AW-1:0] upd0_addr = '0, upd1_addr = '0;
    logic [DW-1:0] upd0_data = '0, upd1_data = '0;
    logic          upd_ready;
    logic          clear_req = 1'b0;
    logic [AW-1:0] wra_addr, wrb_addr;
    logic [DW-1:0] wra_data, wrb_data;
    logic          wra_valid, wrb_valid;
    logic          busy;
    logic [CW-1:0] count;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vtage_vt_write_scheduler #(
        .P_STORAGE_SIZE(SS),
        .P_DATA_WIDTH  (DW),
        .P_QUEUE_DEPTH (QD)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .upd0_valid_i(upd0_valid),
        .upd0_addr_i (upd0_addr),
        .upd0_data_i (upd0_data),
        .upd1_valid_i(upd1_valid),
        .upd1_addr_i (upd1_addr),
        .upd1_data_i (upd1_data),
        .upd_ready_o (upd_ready),
        .clear_req_i (clear_req),
        .wra_addr_o  (wra_addr),
        .wra_data_o  (wra_data),
        .wra_valid_o (wra_valid),
        .wrb_addr_o  (wrb_addr),
        .wrb_data_o  (wrb_data),
        .wrb_valid_o (wrb_valid),
        .busy_o      (busy),
        .count_o     (count)
    );

    task automatic set_upd(input logic v0, input int a0, input int d0,
                           input logic v1, input int a1, input int d1);
        upd0_valid = v0; upd0_addr = AW'(a0); upd0_data = DW'(d0);
        upd1_valid = v1; upd1_addr = AW'(a1); upd1_data = DW'(d1);
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    // Reset then wait for the clear sequence to finish, bounded.
    task automatic reset_and_settle();
        @(negedge clk);
        rst_ni = 1'b0; clear_req = 1'b0;
        set_upd(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b want 1", busy); end
        n_cmp++; if (upd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", upd_ready); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if ({wra_valid, wrb_valid} !== 2'b11) begin n_fail++; $display("FAIL reset_valids got %b want 11", {wra_valid, wrb_valid}); end
        n_cmp++; if (wra_addr !== 3'd0 || wrb_addr !== 3'd1 || wra_data !== 0 || wrb_data !== 0) begin
            n_fail++; $display("FAIL reset_ports got a=%0d b=%0d da=%0h db=%0h want 0 1 0 0", wra_addr, wrb_addr, wra_data, wrb_data);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        for (int i = 0; i < SS / 2; i++) begin
            n_cmp++;
            if (busy !== 1'b1 || wra_addr !== AW'(2 * i) || wrb_addr !== AW'(2 * i + 1) ||
                wra_valid !== 1'b1 || wrb_valid !== 1'b1 || wra_data !== 0 || wrb_data !== 0) begin
                n_fail++;
                $display("FAIL clear_step%0d got busy=%b a=%0d b=%0d va=%b vb=%b want 1 %0d %0d 1 1", i, busy, wra_addr, wrb_addr, wra_valid, wrb_valid, 2 * i, 2 * i + 1);
            end
            next_cycle();
        end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_done_busy got %b want 0", busy); end
        n_cmp++; if (upd_ready !== 1'b1) begin n_fail++; $display("FAIL clear_done_ready got %b want 1", upd_ready); end
        n_cmp++; if ({wra_valid, wrb_valid} !== 2'b00) begin n_fail++; $display("FAIL idle_valids got %b want 00", {wra_valid, wrb_valid}); end
    endtask

    task automatic test_pair();
        reset_and_settle();
        @(negedge clk);
        set_upd(1, 3, 'hA, 1, 5, 'hB);
        #1;
        n_cmp++; if (upd_ready !== 1'b1) begin n_fail++; $display("FAIL pair_ready got %b want 1", upd_ready); end
        @(negedge clk);
        set_upd(0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL pair_count got %0d want 2", count); end
        n_cmp++;
        if (wra_valid !== 1'b1 || wra_addr !== 3'd3 || wra_data !== 32'hA ||
            wrb_valid !== 1'b1 || wrb_addr !== 3'd5 || wrb_data !== 32'hB) begin
            n_fail++;
            $display("FAIL pair_write got a=%b/%0d/%0h b=%b/%0d/%0h want 1/3/a 1/5/b", wra_valid, wra_addr, wra_data, wrb_valid, wrb_addr, wrb_data);
        end
        next_cycle();
        n_cmp++; if (count !== 3'd0 || wra_valid !== 1'b0 || wrb_valid !== 1'b0) begin
            n_fail++; $display("FAIL pair_drained got count=%0d va=%b vb=%b want 0 0 0", count, wra_valid, wrb_valid);
        end
    endtask

    task automatic test_same_addr();
        @(negedge clk);
        set_upd(1, 6, 'h1, 1, 6, 'h2);
        @(negedge clk);
        set_upd(0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++;
        if (wra_valid !== 1'b0 || wrb_valid !== 1'b1 || wrb_addr !== 3'd6 || wrb_data !== 32'h2) begin
            n_fail++;
            $display("FAIL same_addr got va=%b vb=%b b=%0d/%0h want 0 1 6/2", wra_valid, wrb_valid, wrb_addr, wrb_data);
        end
        next_cycle();
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL same_addr_count got %0d want 0", count); end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c < 3) set_upd(1, 2 * c, 'h100 + c, 1, 2 * c + 1, 'h200 + c);
            else set_upd(0, 0, 0, 0, 0, 0);
            #1;
            if (c < 3) begin
                n_cmp++; if (upd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d got %b want 1", c, upd_ready); end
            end
            n_cmp++; if (count > 3'd2) begin n_fail++; $display("FAIL b2b_count%0d got %0d want <=2", c, count); end
            if (c > 0) begin
                n_cmp++;
                if (wra_valid !== 1'b1 || wra_addr !== AW'(2 * c - 2) || wra_data !== DW'('h100 + c - 1) ||
                    wrb_valid !== 1'b1 || wrb_addr !== AW'(2 * c - 1) || wrb_data !== DW'('h200 + c - 1)) begin
                    n_fail++;
                    $display("FAIL b2b_write%0d got a=%b/%0d/%0h b=%b/%0d/%0h", c, wra_valid, wra_addr, wra_data, wrb_valid, wrb_addr, wrb_data);
                end
            end
        end
        next_cycle();
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_final_count got %0d want 0", count); end
    endtask

    task automatic test_clear_in_run();
        @(negedge clk);
        set_upd(1, 1, 'hDEAD, 1, 2, 'hBEEF);
        @(negedge clk);
        set_upd(0, 0, 0, 0, 0, 0);
        clear_req = 1'b1;
        #1;
        n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL clr_run_count_before got %0d want 2", count); end
        n_cmp++; if (wra_valid !== 1'b0 || wrb_valid !== 1'b0) begin
            n_fail++; $display("FAIL clr_run_suppress got va=%b vb=%b want 0 0", wra_valid, wrb_valid);
        end
        @(negedge clk);
        clear_req = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL clr_run_enter got busy=%b count=%0d want 1 0", busy, count); end
        for (int i = 0; i < SS / 2; i++) begin
            n_cmp++;
            if (wra_addr !== AW'(2 * i) || wrb_addr !== AW'(2 * i + 1) || wra_data !== 0 || wrb_data !== 0) begin
                n_fail++; $display("FAIL clr_run_seq%0d got a=%0d b=%0d want %0d %0d", i, wra_addr, wrb_addr, 2 * i, 2 * i + 1);
            end
            next_cycle();
        end
        n_cmp++; if (busy !== 1'b0 || wra_valid !== 1'b0 || wrb_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++; $display("FAIL clr_run_discard got busy=%b va=%b vb=%b count=%0d want 0 0 0 0", busy, wra_valid, wrb_valid, count);
        end
    endtask

    task automatic test_clear_restart();
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear_req = 1'b1;
        #1;
        n_cmp++; if (wra_addr !== 3'd4 || wrb_addr !== 3'd5) begin
            n_fail++; $display("FAIL restart_k2 got a=%0d b=%0d want 4 5", wra_addr, wrb_addr);
        end
        @(negedge clk);
        clear_req = 1'b0;
        #1;
        for (int i = 0; i < SS / 2; i++) begin
            n_cmp++;
            if (busy !== 1'b1 || wra_addr !== AW'(2 * i) || wrb_addr !== AW'(2 * i + 1)) begin
                n_fail++; $display("FAIL restart_seq%0d got busy=%b a=%0d b=%0d want 1 %0d %0d", i, busy, wra_addr, wrb_addr, 2 * i, 2 * i + 1);
            end
            next_cycle();
        end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_done got busy=%b want 0", busy); end
    endtask

    // Reference: clear counter plus an ordered list of pending updates, drained two per cycle.
    task automatic test_random();
        int      m_k;
        bit      m_clearing;
        int      qa[$];
        int      qd[$];
        bit      e_va, e_vb, e_rdy;
        int      e_aa, e_ab, e_da, e_db, npop;
        reset_and_settle();
        m_clearing = 0; m_k = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            rst_ni    = ($urandom_range(0, 99) != 0);
            clear_req = ($urandom_range(0, 39) == 0);
            set_upd($urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom);
            #1;
            npop = 0; e_aa = 0; e_ab = 0; e_da = 0; e_db = 0;
            e_rdy = !m_clearing && (QD - qa.size() >= 2);
            if (m_clearing) begin
                e_va = 1; e_vb = 1; e_aa = 2 * m_k; e_ab = 2 * m_k + 1;
            end else if (clear_req || qa.size() == 0) begin
                e_va = 0; e_vb = 0;
            end else if (qa.size() >= 2) begin
                npop = 2; e_vb = 1; e_ab = qa[1]; e_db = qd[1];
                e_va = (qa[0] != qa[1]); e_aa = qa[0]; e_da = qd[0];
            end else begin
                npop = 1; e_va = 1; e_vb = 0; e_aa = qa[0]; e_da = qd[0];
            end
            n_cmp++;
            if (busy !== m_clearing || upd_ready !== e_rdy || count !== CW'(m_clearing ? 0 : qa.size()) ||
                wra_valid !== e_va || wrb_valid !== e_vb) begin
                n_fail++;
                $display("FAIL rand_ctrl%0d got busy=%b rdy=%b cnt=%0d va=%b vb=%b want %b %b %0d %b %b", cyc,
                         busy, upd_ready, count, wra_valid, wrb_valid, m_clearing, e_rdy, qa.size(), e_va, e_vb);
            end
            if (e_va) begin
                n_cmp++;
                if (wra_addr !== AW'(e_aa) || wra_data !== DW'(e_da)) begin
                    n_fail++; $display("FAIL rand_porta%0d got %0d/%0h want %0d/%0h", cyc, wra_addr, wra_data, e_aa, e_da);
                end
            end
            if (e_vb) begin
                n_cmp++;
                if (wrb_addr !== AW'(e_ab) || wrb_data !== DW'(e_db)) begin
                    n_fail++; $display("FAIL rand_portb%0d got %0d/%0h want %0d/%0h", cyc, wrb_addr, wrb_data, e_ab, e_db);
                end
            end
            if (wra_valid && wrb_valid && !busy) begin
                n_cmp++;
                if (wra_addr === wrb_addr) begin n_fail++; $display("FAIL rand_collide%0d both ports at %0d", cyc, wra_addr); end
            end
            if (!rst_ni) begin
                m_clearing = 1; m_k = 0; qa.delete(); qd.delete();
            end else if (m_clearing) begin
                if (clear_req) m_k = 0;
                else if (m_k == SS / 2 - 1) begin m_clearing = 0; m_k = 0; end
                else m_k++;
            end else if (clear_req) begin
                m_clearing = 1; m_k = 0; qa.delete(); qd.delete();
            end else begin
                for (int p = 0; p < npop; p++) begin void'(qa.pop_front()); void'(qd.pop_front()); end
                if (e_rdy && upd0_valid) begin qa.push_back(int'(upd0_addr)); qd.push_back(int'(upd0_data)); end
                if (e_rdy && upd1_valid) begin qa.push_back(int'(upd1_addr)); qd.push_back(int'(upd1_data)); end
            end
        end
        rst_ni = 1'b1; clear_req = 1'b0;
        set_upd(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_pair();
        test_same_addr();
        test_back_to_back();
        test_clear_in_run();
        test_clear_restart();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vtage_vt_write_scheduler.md
VTAGE_VT_WRITE_SCHEDULER -- requirements
Module: vtage_vt_write_scheduler

Interface
REQ-001 SHALL have parameter P_STORAGE_SIZE, default 2048, number of value-table entries (power of two, >=4).
REQ-002 SHALL have parameter P_DATA_WIDTH, default 32, value width.
REQ-003 SHALL have parameter P_QUEUE_DEPTH, default 4, update-queue entries (power of two, >=2).
REQ-004 SHALL derive localparam LP_ADDRESS_WIDTH = $clog2(P_STORAGE_SIZE).
REQ-005 SHALL have port clk_i  input  1  main clock; one clock only.
REQ-006 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-007 SHALL have ports upd0_valid_i/upd1_valid_i  input  1 each  update requests; upd0 is older.
REQ-008 SHALL have ports upd0_addr_i/upd1_addr_i  input  LP_ADDRESS_WIDTH each  update addresses.
REQ-009 SHALL have ports upd0_data_i/upd1_data_i  input  P_DATA_WIDTH each  update values.
REQ-010 SHALL have port upd_ready_o  output  1  both update slots may be accepted this cycle.
REQ-011 SHALL have port clear_req_i  input  1  request full-table re-initialisation.
REQ-012 SHALL have ports wra_addr_o/wrb_addr_o  output  LP_ADDRESS_WIDTH each  value-table write addresses.
REQ-013 SHALL have ports wra_data_o/wrb_data_o  output  P_DATA_WIDTH each  value-table write data.
REQ-014 SHALL have ports wra_valid_o/wrb_valid_o  output  1 each  value-table write enables.
REQ-015 SHALL have port busy_o  output  1  high while in CLEAR.
REQ-016 SHALL have port count_o  output  $clog2(P_QUEUE_DEPTH+1)  queue occupancy.

Function
REQ-017 SHALL implement FSM states CLEAR and RUN; no other states.
REQ-018 SHALL in CLEAR, with counter k, drive wra_addr_o=2k, wrb_addr_o=2k+1, data 0, both valids 1, k incrementing once per cycle.
REQ-019 SHALL go CLEAR->RUN after the cycle with k=P_STORAGE_SIZE/2-1; clear thus takes P_STORAGE_SIZE/2 cycles.
REQ-020 SHALL on clear_req_i=1 in RUN enter CLEAR next cycle with k=0, discarding all queued updates (count_o=0).
REQ-021 SHALL on clear_req_i=1 in CLEAR restart k at 0 next cycle.
REQ-022 SHALL drive upd_ready_o = (state==RUN) && (P_QUEUE_DEPTH-count_o >= 2), computed from registered count only (no same-cycle pop credit).
REQ-023 SHALL on a cycle with upd_ready_o=1 enqueue upd0 if valid, then upd1 if valid, preserving order; upd1 alone occupies one slot.
REQ-024 SHALL ignore update valids when upd_ready_o=0; requesters hold them.
REQ-025 SHALL in RUN drain per cycle: head on port a, head+1 on port b if present; pop count equals entries driven.
REQ-026 SHALL when head and head+1 share an address, deassert wra_valid_o, drive the younger (head+1) on port b, and pop both.
REQ-027 SHALL drive write ports combinationally from registered queue state: an update accepted at edge N is written in cycle N+1 at the earliest.
REQ-028 SHALL drive wra_valid_o=wrb_valid_o=0 in RUN with an empty queue; addr/data then don't-care.
REQ-029 SHALL handle simultaneous enqueue and drain in one cycle; count_o(next) = count + pushes - pops, never exceeding P_QUEUE_DEPTH.
REQ-030 SHALL wrap read/write pointers modulo P_QUEUE_DEPTH.
REQ-031 SHALL never drive wra and wrb to the same address with both valids high.

Reset
REQ-032 SHALL on rst_ni=0 at a clock edge enter CLEAR with k=0, count_o=0, pointers 0, regardless of state.
REQ-033 SHALL drive during and after reset: busy_o=1, upd_ready_o=0, wra/wrb_addr_o=0/1, data 0, valids 1 (CLEAR, k=0).
REQ-034 SHALL discard queue contents on reset asserted mid-operation; no in-flight update is written afterwards.

Verification (P_STORAGE_SIZE=8, P_QUEUE_DEPTH=4 unless stated)
REQ-035 SHALL cover reset release -> 4 cycles writing (0,1),(2,3),(4,5),(6,7) data 0, then busy_o=0, upd_ready_o=1.
REQ-036 SHALL cover in RUN, upd0={3,0xA}, upd1={5,0xB} -> next cycle wra={3,0xA}, wrb={5,0xB}, both valid; count_o returns to 0.
REQ-037 SHALL cover upd0={6,0x1}, upd1={6,0x2} -> next cycle wra_valid_o=0, wrb={6,0x2} valid.
REQ-038 SHALL cover 3 consecutive cycles pushing 2 updates while downstream drains -> upd_ready_o stays 1, writes emitted in order, count_o <=2.
REQ-039 SHALL cover clear_req_i with count_o=2 -> next cycle busy_o=1, count_o=0, queued updates never written, clear sequence from k=0.
REQ-040 SHALL cover clear_req_i pulsed at k=2 of CLEAR -> next cycle addresses (0,1), total clear extends to restart+4 cycles.
